// File: rtl/hex_display_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_mux_if
// Desc     : Value/control bundle between a producer and the display scanner.
// Revision : 1.0 initial release
// ============================================================================
interface hex_display_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] data;
   logic [NUM_DIGITS-1:0]   dp;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    blank_lz;
   logic [3:0]              brightness;
   logic                    load;
   logic                    pending;
   logic                    frame_start;
   logic [NUM_DIGITS-1:0]   anode;
   logic [7:0]              segment;

   modport master (
      output data, dp, digit_en, blank_lz, brightness, load,
      input  pending, frame_start, anode, segment
   );

   modport slave (
      input  data, dp, digit_en, blank_lz, brightness, load,
      output pending, frame_start, anode, segment
   );
endinterface
`default_nettype wire

// File: rtl/hex_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_mux
// Desc     : Multiplexed seven-segment scanner, double-buffered values, PWM dim.
// Revision : 1.0 initial release
// ============================================================================
module hex_display_mux #(
   parameter int NUM_DIGITS       = 4,
   parameter int REFRESH_DIV      = 100000,
   parameter bit ANODE_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   hex_display_mux_if.slave bus
);
   localparam int SLOT_W = $clog2(REFRESH_DIV);
   localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SLOT_W-1:0]     c_slot_last = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0]     c_slot_one  = SLOT_W'(1);
   localparam logic [DIG_W-1:0]      c_dig_last  = DIG_W'(NUM_DIGITS - 1);
   localparam logic [DIG_W-1:0]      c_dig_one   = DIG_W'(1);
   localparam logic [NUM_DIGITS-1:0] c_anode_lsb = NUM_DIGITS'(1);
   localparam logic [NUM_DIGITS-1:0] c_anode_off = ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [7:0]            c_seg_off   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [SLOT_W-1:0]       r_slot_cnt;
   logic [DIG_W-1:0]        r_digit_idx;
   logic [3:0]              r_pwm_cnt;
   logic [4*NUM_DIGITS-1:0] r_pend_data;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic                    r_pending;
   logic [4*NUM_DIGITS-1:0] r_disp_data;
   logic [NUM_DIGITS-1:0]   r_disp_dp;
   logic [3:0]              r_bright;
   logic                    r_blank_lz;
   logic [NUM_DIGITS-1:0]   r_anode;
   logic [7:0]              r_segment;
   logic                    r_frame_start;

   logic                    w_slot_wrap;
   logic                    w_boundary;
   logic [NUM_DIGITS-1:0]   w_blanked;
   logic                    w_run;
   logic [3:0]              w_nibble;
   logic                    w_dp_cur;
   logic                    w_lit;
   logic [7:0]              w_seg_on;
   logic [NUM_DIGITS-1:0]   w_anode_on;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   assign w_slot_wrap = (r_slot_cnt == c_slot_last);
   assign w_boundary  = w_slot_wrap && (r_digit_idx == c_dig_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= '0;
         r_pwm_cnt   <= 4'd0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
         if (w_slot_wrap) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == c_dig_last) ? '0 : r_digit_idx + c_dig_one;
         end else begin
            r_slot_cnt <= r_slot_cnt + c_slot_one;
         end
      end
   end

   // A load coinciding with the frame boundary bypasses the pending buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_data <= '0;
         r_pend_dp   <= '0;
         r_pending   <= 1'b0;
         r_disp_data <= '0;
         r_disp_dp   <= '0;
      end else if (w_boundary && bus.load) begin
         r_disp_data <= bus.data;
         r_disp_dp   <= bus.dp;
         r_pending   <= 1'b0;
      end else if (w_boundary && r_pending) begin
         r_disp_data <= r_pend_data;
         r_disp_dp   <= r_pend_dp;
         r_pending   <= 1'b0;
      end else if (bus.load) begin
         r_pend_data <= bus.data;
         r_pend_dp   <= bus.dp;
         r_pending   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bright   <= 4'hF;
         r_blank_lz <= 1'b0;
      end else if (w_boundary) begin
         r_bright   <= bus.brightness;
         r_blank_lz <= bus.blank_lz;
      end
   end

   // Blanking runs from the most significant digit down; digit 0 is never blanked.
   always_comb begin
      w_blanked = '0;
      w_run     = r_blank_lz;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         w_run        = w_run & (r_disp_data[4*k +: 4] == 4'h0) & ~r_disp_dp[k];
         w_blanked[k] = w_run;
      end
   end

   assign w_nibble   = r_disp_data[{r_digit_idx, 2'b00} +: 4];
   assign w_dp_cur   = r_disp_dp[r_digit_idx];
   assign w_seg_on   = {w_dp_cur, hex_to_seg(w_nibble)};
   assign w_anode_on = c_anode_lsb << r_digit_idx;
   assign w_lit      = (r_slot_cnt != '0) && bus.digit_en[r_digit_idx] &&
                       !w_blanked[r_digit_idx] && (r_pwm_cnt <= r_bright);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_anode       <= c_anode_off;
         r_segment     <= c_seg_off;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= (r_digit_idx == '0) && (r_slot_cnt == '0);
         if (w_lit) begin
            r_anode   <= w_anode_on ^ c_anode_off;
            r_segment <= w_seg_on ^ c_seg_off;
         end else begin
            r_anode   <= c_anode_off;
            r_segment <= c_seg_off;
         end
      end
   end

   assign bus.pending     = r_pending;
   assign bus.frame_start = r_frame_start;
   assign bus.anode       = r_anode;
   assign bus.segment     = r_segment;
endmodule
`default_nettype wire

// File: doc/hex_display_mux.md
# hex_display_mux

Parametrised multiplexed seven-segment display driver for the board top level, the successor to the fixed 4-digit hex display path. It scans NUM_DIGITS hex digits onto shared segment lines, with per-digit enable, decimal points, optional leading-zero blanking and 16-level PWM brightness. Input values are double-buffered so an update never tears mid-frame. It sits between any value producer (counters, CPU debug registers) and the `anode`/`segment` board pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 100000, clock cycles per digit slot (>= 2)
- ANODE_ACTIVE_LOW, 1, anode outputs low = digit on
- SEG_ACTIVE_LOW, 1, segment outputs low = segment lit
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- data  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k (digit 0 rightmost)
- dp  input  NUM_DIGITS  decimal point request per digit
- digit_en  input  NUM_DIGITS  per-digit enable; 0 = digit dark
- blank_lz  input  1  1 = blank leading zero digits
- brightness  input  4  PWM duty, 0 = 1/16, 15 = full
- load  input  1  one-cycle strobe, capture data/dp into pending buffer
- pending  output  1  buffered value not yet committed
- frame_start  output  1  one-cycle pulse at start of each scan frame
- anode  output  NUM_DIGITS  digit select
- segment  output  8  segment[0..6] = a..g, segment[7] = dp

## Operation
- Internal counters: slot_cnt 0..REFRESH_DIV-1; digit_idx 0..NUM_DIGITS-1, advances when slot_cnt wraps; pwm_cnt 4-bit free-running, +1 every clock, wraps 15->0.
- Frame = NUM_DIGITS*REFRESH_DIV cycles; boundary = edge where digit_idx/slot_cnt move from (NUM_DIGITS-1, REFRESH_DIV-1) to (0,0).
- Buffering: load captures data, dp into pending regs, sets pending=1. At frame boundary, if pending=1, pending regs copy into display regs, pending clears. load on the boundary edge itself: input data/dp commit straight to display regs, pending stays 0. Repeated loads before boundary: last one wins.
- brightness and blank_lz sampled only at frame boundary (constant within frame). digit_en, read live.
- Leading-zero blanking (blank_lz=1): scanning from digit NUM_DIGITS-1 downward, a digit is blanked while its nibble is 0 and its dp is 0; first non-zero nibble or set dp ends blanking. Digit 0 never blanked.
- Digit k lit iff digit_idx==k, slot_cnt!=0 (guard slot, anti-ghosting), digit_en[k]=1, not blanked, and pwm_cnt <= brightness.
- Decode (active-high before polarity): 0 3F,1 06,2 5B,3 4F,4 66,5 6D,6 7D,7 07,8 7F,9 6F,A 77,b 7C,C 39,d 5E,E 79,F 71. segment[7] = display dp[digit_idx].
- Dark digit: all anodes inactive and all segments inactive.
- Polarity params invert the final registered outputs only.

## Timing
- Reset (async assert, sync-released internally by flops on clk): slot_cnt=0, digit_idx=0, pwm_cnt=0, display and pending regs 0, pending=0, frame_start=0, anode all inactive (all 1 with default), segment all inactive (0xFF with default), latched brightness=15, blank_lz latch=0.
- anode, segment, frame_start are registered: they reflect counter state of the previous cycle (1-cycle latency).
- frame_start high exactly one cycle, the cycle outputs show digit 0 slot 0; first such pulse is one cycle after the first post-reset edge.
- pending rises the cycle after load; falls the cycle after the boundary edge; values committed at a boundary are visible from slot 1 of digit 0 of that frame.
- Reset mid-frame: outputs go inactive immediately (asynchronous), pending data discarded.
- digit_en change: takes effect on next output register update (1 cycle).

## Test plan
- Reset scan, NUM_DIGITS=4, REFRESH_DIV=4, brightness=15, all digit_en=1, blank_lz=0: anode sequence per digit = 1111 (guard) then 1110 x3, then 1111,1101 x3, ...; segment 0xC0 on each lit cycle; frame_start every 16 cycles.
- load data=0x12AF mid-frame at digit 1: pending=1 next cycle; display unchanged until boundary; next frame digits 0..3 show 0x8E,0x88,0xA4,0xF9; pending=0 after boundary.
- load asserted on boundary edge with data=0x0005: committed same frame, pending never rises; second load of 0x0006 in same frame appears only next frame.
- blank_lz=1, data=0x0050, dp=0000: digits 3,2 dark, digit 1 = 0x92, digit 0 = 0xC0; with dp[3]=1 digit 3 shows 0x40, digit 2 shows 0xC0.
- brightness=0 latched: each lit slot cycle active only when pwm_cnt==0 (1 of 16 cycles, REFRESH_DIV=64); brightness changed mid-frame has no effect until next frame_start.
- Assert rst_n=0 mid-digit 2: anode=1111, segment=0xFF in same cycle without clock edge; after release scan restarts at digit 0, display=0.
